// File: rtl/mem_bus_arbiter_if.sv
// Cache/memory bus bundle for mem_bus_arbiter.
// slave = arbiter side, master = caches plus memory model.
interface mem_bus_arbiter_if;
  logic [1:0]  icache_command;
  logic [63:0] icache_addr;
  logic [1:0]  dcache_command;
  logic [63:0] dcache_addr;
  logic [63:0] dcache_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  Icache_response;
  logic [3:0]  Dcache_response;
  logic [3:0]  Icache_tag;
  logic [3:0]  Dcache_tag;
  logic [63:0] Icache_data;
  logic [63:0] Dcache_data;
  logic [4:0]  i_outstanding;
  logic [4:0]  d_outstanding;

  modport slave (
    input  icache_command, icache_addr,
    input  dcache_command, dcache_addr,
    input  dcache_data,
    input  mem2proc_response, mem2proc_data,
    input  mem2proc_tag,
    output proc2mem_command, proc2mem_addr,
    output proc2mem_data,
    output Icache_response, Dcache_response,
    output Icache_tag, Dcache_tag,
    output Icache_data, Dcache_data,
    output i_outstanding, d_outstanding
  );

  modport master (
    output icache_command, icache_addr,
    output dcache_command, dcache_addr,
    output dcache_data,
    output mem2proc_response, mem2proc_data,
    output mem2proc_tag,
    input  proc2mem_command, proc2mem_addr,
    input  proc2mem_data,
    input  Icache_response, Dcache_response,
    input  Icache_tag, Dcache_tag,
    input  Icache_data, Dcache_data,
    input  i_outstanding, d_outstanding
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// icache/dcache arbiter for the shared memory port with tag routing.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts (else dcache wins).
module mem_bus_arbiter #(
  parameter int I_MAX_OUTSTANDING = 8,
  parameter int D_MAX_OUTSTANDING = 15
) (
  input logic clock,
  input logic reset,
  mem_bus_arbiter_if.slave bus
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [4:0] I_MAX = 5'(I_MAX_OUTSTANDING);
  localparam logic [4:0] D_MAX = 5'(D_MAX_OUTSTANDING);

  logic [15:0] tbl_valid;
  logic [15:0] tbl_owner;
  logic [4:0]  i_cnt;
  logic [4:0]  d_cnt;

  logic i_elig, d_elig;
  logic pick_d;
  logic grant_i, grant_d;
  logic accepted;
  logic i_alloc, d_alloc;
  logic ret_hit, ret_d;
  logic i_ret, d_ret;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;
  // rr_ptr = 1 means the dcache holds the last accepted grant.
  assign pick_d = !rr_ptr;
`else
  assign pick_d = 1'b1;
`endif

  assign i_elig = (bus.icache_command != BUS_NONE)
                  && (i_cnt < I_MAX);
  assign d_elig = ((bus.dcache_command == BUS_LOAD)
                   && (d_cnt < D_MAX))
                  || (bus.dcache_command == BUS_STORE);

  assign grant_d = d_elig && (!i_elig || pick_d);
  assign grant_i = i_elig && !grant_d;

  assign accepted = |bus.mem2proc_response;
  assign i_alloc  = accepted && grant_i
                    && (bus.icache_command == BUS_LOAD);
  assign d_alloc  = accepted && grant_d
                    && (bus.dcache_command == BUS_LOAD);

  assign ret_hit = |bus.mem2proc_tag
                   && tbl_valid[bus.mem2proc_tag];
  assign ret_d   = tbl_owner[bus.mem2proc_tag];
  assign i_ret   = ret_hit && !ret_d;
  assign d_ret   = ret_hit && ret_d;

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.Icache_response  = '0;
    bus.Dcache_response  = '0;
    bus.Icache_tag       = '0;
    bus.Dcache_tag       = '0;
    bus.Icache_data      = '0;
    bus.Dcache_data      = '0;
    bus.i_outstanding    = '0;
    bus.d_outstanding    = '0;
    if (!reset) begin
      unique case (1'b1)
        grant_d: begin
          bus.proc2mem_command = bus.dcache_command;
          bus.proc2mem_addr    = bus.dcache_addr;
          bus.proc2mem_data    = bus.dcache_data;
          bus.Dcache_response  = bus.mem2proc_response;
        end
        grant_i: begin
          bus.proc2mem_command = bus.icache_command;
          bus.proc2mem_addr    = bus.icache_addr;
          bus.Icache_response  = bus.mem2proc_response;
        end
        default: ;
      endcase
      if (i_ret) bus.Icache_tag = bus.mem2proc_tag;
      if (d_ret) bus.Dcache_tag = bus.mem2proc_tag;
      bus.Icache_data   = bus.mem2proc_data;
      bus.Dcache_data   = bus.mem2proc_data;
      bus.i_outstanding = i_cnt;
      bus.d_outstanding = d_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_valid <= '0;
      tbl_owner <= '0;
      i_cnt     <= '0;
      d_cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      if (ret_hit)
        tbl_valid[bus.mem2proc_tag] <= 1'b0;
      // Allocation after the clear so a reused tag keeps the new owner.
      if (i_alloc || d_alloc) begin
        tbl_valid[bus.mem2proc_response] <= 1'b1;
        tbl_owner[bus.mem2proc_response] <= d_alloc;
      end
      i_cnt <= i_cnt + 5'(i_alloc) - 5'(i_ret);
      d_cnt <= d_cnt + 5'(d_alloc) - 5'(d_ret);
`ifdef ARB_ROUND_ROBIN_EN
      if (accepted && (grant_i || grant_d))
        rr_ptr <= grant_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed plan plus random traffic
// checked against a tag-ownership reference model.
module tb_mem_bus_arbiter;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam int IMAX = 8;
  localparam int DMAX = 15;

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  ir;
    logic [3:0]  dr;
    logic [3:0]  it;
    logic [3:0]  dt;
    logic [63:0] idata;
    logic [63:0] ddata;
    logic [4:0]  io;
    logic [4:0]  dout;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t q[$];

  // owner[t]: -1 free, 0 icache, 1 dcache
  int owner[16];
  bit last_d = 1'b0;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  function automatic int cnt(int who);
    int n = 0;
    for (int t = 1; t < 16; t++)
      if (owner[t] == who) n++;
    return n;
  endfunction

  // 0 = no grant, 1 = icache, 2 = dcache
  function automatic int grant(logic [1:0] ic, logic [1:0] dc);
    bit ie, de;
    ie = (ic != NONE) && (cnt(0) < IMAX);
    de = ((dc == LOAD) && (cnt(1) < DMAX)) || (dc == STORE);
    if (ie && de) begin
`ifdef ARB_ROUND_ROBIN_EN
      return last_d ? 1 : 2;
`else
      return 2;
`endif
    end
    if (de) return 2;
    if (ie) return 1;
    return 0;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step(input bit rst,
                      input logic [1:0] ic,
                      input logic [1:0] dc,
                      input logic [3:0] rsp,
                      input logic [3:0] tg);
    exp_t e;
    int g;
    logic [63:0] ia, da, dd, md;
    @(posedge clock);
    #1;
    ia = rnd64();
    da = rnd64();
    dd = rnd64();
    md = rnd64();
    reset = rst;
    bus.icache_command = ic;
    bus.icache_addr = ia;
    bus.dcache_command = dc;
    bus.dcache_addr = da;
    bus.dcache_data = dd;
    bus.mem2proc_response = rsp;
    bus.mem2proc_data = md;
    bus.mem2proc_tag = tg;
    e = '{default: '0};
    if (rst) begin
      q.push_back(e);
      for (int t = 0; t < 16; t++) owner[t] = -1;
      last_d = 1'b0;
    end else begin
      g = grant(ic, dc);
      if (g == 1) begin
        e.cmd = ic; e.addr = ia; e.ir = rsp;
      end else if (g == 2) begin
        e.cmd = dc; e.addr = da; e.data = dd; e.dr = rsp;
      end
      if (tg != 0 && owner[tg] == 0) e.it = tg;
      if (tg != 0 && owner[tg] == 1) e.dt = tg;
      e.idata = md;
      e.ddata = md;
      e.io = 5'(cnt(0));
      e.dout = 5'(cnt(1));
      q.push_back(e);
      if (tg != 0) owner[tg] = -1;
      if (rsp != 0 && g == 1 && ic == LOAD) owner[rsp] = 0;
      if (rsp != 0 && g == 2 && dc == LOAD) owner[rsp] = 1;
      if (rsp != 0 && g != 0) last_d = (g == 2);
    end
  endtask

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               n, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("proc2mem_command", 64'(bus.proc2mem_command), 64'(e.cmd));
        chk("proc2mem_addr", bus.proc2mem_addr, e.addr);
        chk("proc2mem_data", bus.proc2mem_data, e.data);
        chk("Icache_response", 64'(bus.Icache_response), 64'(e.ir));
        chk("Dcache_response", 64'(bus.Dcache_response), 64'(e.dr));
        chk("Icache_tag", 64'(bus.Icache_tag), 64'(e.it));
        chk("Dcache_tag", 64'(bus.Dcache_tag), 64'(e.dt));
        chk("Icache_data", bus.Icache_data, e.idata);
        chk("Dcache_data", bus.Dcache_data, e.ddata);
        chk("i_outstanding", 64'(bus.i_outstanding), 64'(e.io));
        chk("d_outstanding", 64'(bus.d_outstanding), 64'(e.dout));
      end
    end
  end

  initial begin
    int tags[$];
    int g, r;
    logic [1:0] ic, dc;
    logic [3:0] rsp, tg;
    bit rst;
    for (int t = 0; t < 16; t++) owner[t] = -1;
    bus.icache_command = NONE;
    bus.icache_addr = '0;
    bus.dcache_command = NONE;
    bus.dcache_addr = '0;
    bus.dcache_data = '0;
    bus.mem2proc_response = '0;
    bus.mem2proc_data = '0;
    bus.mem2proc_tag = '0;

    step(1, NONE, NONE, 0, 0);
    step(1, NONE, NONE, 0, 0);
    // icache load, tag back two cycles later
    step(0, LOAD, NONE, 3, 0);
    step(0, NONE, NONE, 0, 0);
    step(0, NONE, NONE, 0, 3);
    step(0, NONE, NONE, 0, 0);
    // conflicts after reset
    step(1, NONE, NONE, 0, 0);
    step(0, LOAD, LOAD, 5, 0);
    step(0, LOAD, LOAD, 6, 0);
    step(0, LOAD, LOAD, 7, 0);
    // store: not recorded, tag dropped
    step(1, NONE, NONE, 0, 0);
    step(0, NONE, STORE, 2, 0);
    step(0, NONE, NONE, 0, 2);
    // icache outstanding limit
    step(1, NONE, NONE, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, LOAD, NONE, 4'(i), 0);
    step(0, LOAD, NONE, 9, 0);
    step(0, LOAD, NONE, 9, 1);
    step(0, LOAD, NONE, 9, 0);
    // same-cycle return and reallocation of tag 4
    step(1, NONE, NONE, 0, 0);
    step(0, LOAD, NONE, 4, 0);
    step(0, NONE, LOAD, 4, 4);
    step(0, NONE, NONE, 0, 0);
    // reset drops in-flight ownership
    step(1, NONE, NONE, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, LOAD, NONE, 4'(i), 0);
    step(1, NONE, NONE, 0, 0);
    step(0, NONE, NONE, 0, 1);
    step(0, NONE, NONE, 0, 2);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      ic = ($urandom_range(0, 99) < 60) ? LOAD : NONE;
      r = $urandom_range(0, 99);
      dc = (r < 35) ? LOAD : (r < 55) ? STORE : NONE;
      tg = 0;
      r = $urandom_range(0, 99);
      tags.delete();
      for (int t = 1; t < 16; t++)
        if (owner[t] >= 0) tags.push_back(t);
      if (r < 30 && tags.size() > 0)
        tg = 4'(tags[$urandom_range(0, tags.size() - 1)]);
      else if (r < 40)
        tg = 4'($urandom_range(1, 15));
      rsp = 0;
      g = grant(ic, dc);
      if (g != 0 && $urandom_range(0, 99) < 80) begin
        tags.delete();
        for (int t = 1; t < 16; t++)
          if (owner[t] < 0 || t == int'(tg)) tags.push_back(t);
        if (tags.size() > 0)
          rsp = 4'(tags[$urandom_range(0, tags.size() - 1)]);
      end
      step(rst, ic, dc, rsp, tg);
    end

    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
